// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//
// Microcoded fetch/decode/execute controller for memory_system. It issues every
// datapath control signal and consumes the IR opcode and the ALU flags.
//
// Optional feature macro: CU_COND_JUMP_EN
//   defined   -> opcodes 5'h06 (JZ) and 5'h07 (JC) load PC from DPTR when
//                Z (resp. C), sampled in DEC, is set.
//   undefined -> 5'h06/5'h07 decode as NOP and the flag inputs are unused.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   run                 level; start/resume request
//   instruction[4:0]    IR opcode from the datapath, decoded in DEC
//   C, N, P, Z          ALU flags
//   ir_sclr, mar_sclr   synchronous clears of IR/MAR
//   enaf                flag update enable
//   selop[2:0]          ALU operation
//   shamt[1:0]          shift amount
//   bank_wr_en          register bank write enable
//   busB_addr[2:0]      register bank read address
//   busC_addr[2:0]      register bank write address
//   ir_en, mar_en,
//   mdr_en              register loads
//   wr_rdn              memory write (1) / read (0)
//   mdr_alu_n           MDR source: memory (1) / ALU (0)
//   halted              high in IDLE and HALT
//   state_m[3:0]        current state, for monitoring
//
// Timing: every output is a register. The control word belonging to a state is
// computed from the next state and loaded on the same edge that enters that
// state, so outputs and state_m always describe the same state; the datapath
// acts on the word at the following edge.
//
// Handshake: none. run is a level; a 0->1 transition seen against a registered
// copy of run is the only event that leaves HALT.
// -----------------------------------------------------------------------------
module control_sequencer #(
    parameter int         DATA_WIDTH = 8,
    parameter logic [2:0] PC_ADDR    = 3'd0,
    parameter logic [2:0] DPTR_ADDR  = 3'd1,
    parameter logic [2:0] ACC_ADDR   = 3'd3,
    parameter logic [2:0] A_ADDR     = 3'd7,
    parameter logic [2:0] OP_PASS    = 3'b000,
    parameter logic [2:0] OP_INC     = 3'b001,
    parameter logic [2:0] OP_ADD     = 3'b010,
    parameter logic [2:0] OP_SHL     = 3'b101
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [4:0] instruction,
    input  logic       C,
    input  logic       N,
    input  logic       P,
    input  logic       Z,
    output logic       ir_sclr,
    output logic       mar_sclr,
    output logic       enaf,
    output logic [2:0] selop,
    output logic [1:0] shamt,
    output logic       bank_wr_en,
    output logic [2:0] busB_addr,
    output logic [2:0] busC_addr,
    output logic       ir_en,
    output logic       mar_en,
    output logic       mdr_en,
    output logic       wr_rdn,
    output logic       mdr_alu_n,
    output logic       halted,
    output logic [3:0] state_m
);

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_INIT = 4'd1;
    localparam logic [3:0] S_F0   = 4'd2;
    localparam logic [3:0] S_F1   = 4'd3;
    localparam logic [3:0] S_F2   = 4'd4;
    localparam logic [3:0] S_DEC  = 4'd5;
    localparam logic [3:0] S_E0   = 4'd6;
    localparam logic [3:0] S_E1   = 4'd7;
    localparam logic [3:0] S_E2   = 4'd8;
    localparam logic [3:0] S_HALT = 4'd9;

    localparam logic [4:0] OPC_NOP   = 5'h00;
    localparam logic [4:0] OPC_MOVAA = 5'h01;   // MOV ACC,A
    localparam logic [4:0] OPC_MOVAC = 5'h02;   // MOV A,ACC
    localparam logic [4:0] OPC_ADD   = 5'h03;
    localparam logic [4:0] OPC_SHL   = 5'h04;
    localparam logic [4:0] OPC_ST    = 5'h05;
    localparam logic [4:0] OPC_HALT  = 5'h1F;
`ifdef CU_COND_JUMP_EN
    localparam logic [4:0] OPC_JZ    = 5'h06;
    localparam logic [4:0] OPC_JC    = 5'h07;
`endif

    logic [3:0] state;
    logic [3:0] next_state;
    logic       run_q;
    logic [4:0] op_q;
    logic [4:0] cur_op;

    logic       n_ir_sclr, n_mar_sclr, n_enaf, n_bank_wr_en;
    logic [2:0] n_selop, n_busB_addr, n_busC_addr;
    logic [1:0] n_shamt;
    logic       n_ir_en, n_mar_en, n_mdr_en, n_wr_rdn, n_mdr_alu_n, n_halted;

    // N and P have no consumer yet, and C/Z only feed the optional jumps.
    logic unused_inputs;
    assign unused_inputs = ^{C, N, P, Z} ^ (DATA_WIDTH == 0);

`ifdef CU_COND_JUMP_EN
    logic take_now;
    logic take_q;
    logic cur_take;
    // Flags are sampled in DEC only; the decision is held for E0.
    assign take_now = ((instruction == OPC_JZ) && Z) || ((instruction == OPC_JC) && C);
    assign cur_take = (state == S_DEC) ? take_now : take_q;
`endif

    // The opcode is live on the input during DEC and held in op_q afterwards.
    assign cur_op  = (state == S_DEC) ? instruction : op_q;
    assign state_m = state;

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (run) next_state = S_INIT;
            S_INIT: next_state = S_F0;
            S_F0:   next_state = S_F1;
            S_F1:   next_state = S_F2;
            S_F2:   next_state = S_DEC;
            S_DEC:  next_state = (instruction == OPC_HALT) ? S_HALT : S_E0;
            S_E0: begin
                if (op_q == OPC_ST) next_state = S_E1;
                else                next_state = run ? S_F0 : S_IDLE;
            end
            S_E1:   next_state = S_E2;
            S_E2:   next_state = run ? S_F0 : S_IDLE;
            S_HALT: if (run && !run_q) next_state = S_INIT;
            default: next_state = S_IDLE;
        endcase
    end

    // Control word of the state being entered.
    always_comb begin
        n_ir_sclr    = 1'b0;
        n_mar_sclr   = 1'b0;
        n_enaf       = 1'b0;
        n_selop      = 3'b000;
        n_shamt      = 2'b00;
        n_bank_wr_en = 1'b0;
        n_busB_addr  = 3'd0;
        n_busC_addr  = 3'd0;
        n_ir_en      = 1'b0;
        n_mar_en     = 1'b0;
        n_mdr_en     = 1'b0;
        n_wr_rdn     = 1'b0;
        n_mdr_alu_n  = 1'b0;
        n_halted     = (next_state == S_IDLE) || (next_state == S_HALT);
        case (next_state)
            S_INIT: begin
                n_ir_sclr  = 1'b1;
                n_mar_sclr = 1'b1;
            end
            S_F0: begin
                n_busB_addr = PC_ADDR;
                n_selop     = OP_PASS;
                n_mar_en    = 1'b1;
            end
            S_F1: begin
                // Memory read into MDR while PC is incremented in the bank.
                n_mdr_alu_n  = 1'b1;
                n_mdr_en     = 1'b1;
                n_busB_addr  = PC_ADDR;
                n_busC_addr  = PC_ADDR;
                n_selop      = OP_INC;
                n_bank_wr_en = 1'b1;
            end
            S_F2: n_ir_en = 1'b1;
            S_E0: begin
                case (cur_op)
                    OPC_MOVAA: begin
                        n_busB_addr  = A_ADDR;
                        n_busC_addr  = ACC_ADDR;
                        n_selop      = OP_PASS;
                        n_bank_wr_en = 1'b1;
                        n_enaf       = 1'b1;
                    end
                    OPC_MOVAC: begin
                        n_busB_addr  = ACC_ADDR;
                        n_busC_addr  = A_ADDR;
                        n_selop      = OP_PASS;
                        n_bank_wr_en = 1'b1;
                        n_enaf       = 1'b1;
                    end
                    OPC_ADD: begin
                        n_busB_addr  = A_ADDR;
                        n_busC_addr  = ACC_ADDR;
                        n_selop      = OP_ADD;
                        n_bank_wr_en = 1'b1;
                        n_enaf       = 1'b1;
                    end
                    OPC_SHL: begin
                        n_busB_addr  = ACC_ADDR;
                        n_busC_addr  = ACC_ADDR;
                        n_selop      = OP_SHL;
                        n_shamt      = 2'b01;
                        n_bank_wr_en = 1'b1;
                        n_enaf       = 1'b1;
                    end
                    OPC_ST: begin
                        n_busB_addr = DPTR_ADDR;
                        n_selop     = OP_PASS;
                        n_mar_en    = 1'b1;
                    end
`ifdef CU_COND_JUMP_EN
                    OPC_JZ, OPC_JC: begin
                        if (cur_take) begin
                            n_busB_addr  = DPTR_ADDR;
                            n_busC_addr  = PC_ADDR;
                            n_selop      = OP_PASS;
                            n_bank_wr_en = 1'b1;
                        end
                    end
`endif
                    OPC_NOP: ;
                    default: ;  // undefined opcodes behave as NOP
                endcase
            end
            S_E1: begin
                // Only ST reaches E1: ACC through the ALU into MDR.
                n_busB_addr = ACC_ADDR;
                n_selop     = OP_PASS;
                n_mdr_alu_n = 1'b0;
                n_mdr_en    = 1'b1;
            end
            S_E2: n_wr_rdn = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            run_q      <= 1'b0;
            op_q       <= OPC_NOP;
            ir_sclr    <= 1'b0;
            mar_sclr   <= 1'b0;
            enaf       <= 1'b0;
            selop      <= 3'b000;
            shamt      <= 2'b00;
            bank_wr_en <= 1'b0;
            busB_addr  <= 3'd0;
            busC_addr  <= 3'd0;
            ir_en      <= 1'b0;
            mar_en     <= 1'b0;
            mdr_en     <= 1'b0;
            wr_rdn     <= 1'b0;
            mdr_alu_n  <= 1'b0;
            halted     <= 1'b1;
        end else begin
            state      <= next_state;
            run_q      <= run;
            if (state == S_DEC) op_q <= instruction;
            ir_sclr    <= n_ir_sclr;
            mar_sclr   <= n_mar_sclr;
            enaf       <= n_enaf;
            selop      <= n_selop;
            shamt      <= n_shamt;
            bank_wr_en <= n_bank_wr_en;
            busB_addr  <= n_busB_addr;
            busC_addr  <= n_busC_addr;
            ir_en      <= n_ir_en;
            mar_en     <= n_mar_en;
            mdr_en     <= n_mdr_en;
            wr_rdn     <= n_wr_rdn;
            mdr_alu_n  <= n_mdr_alu_n;
            halted     <= n_halted;
        end
    end

`ifdef CU_COND_JUMP_EN
    always_ff @(posedge clk) begin
        if (rst)                 take_q <= 1'b0;
        else if (state == S_DEC) take_q <= take_now;
    end
`endif

endmodule
